answer_check: RTL
=================

ANSWER_CHECK -- requirements
Module: answer_check

Interface
REQ-001 SHALL have parameter TIMEOUT_S, default 10, answer window length in seconds (1..255).
REQ-002 SHALL have parameter RESULT_S, default 3, result hold time in seconds (1..255).
REQ-003 SHALL have parameter MAX_GUESS, default 255, highest guess value allowed.
REQ-004 SHALL have port Clk100M  in  1  sole clock; all logic is on the rising edge.
REQ-005 SHALL have port Rst_n  in  1  reset: asynchronous and active-low.
REQ-006 SHALL have port secTick  in  1  one-cycle pulse once per second, synchronous to Clk100M.
REQ-007 SHALL have port answerSig  in  1  one-cycle pulse marking the end of a game period.
REQ-008 SHALL have port numSpecial  in  8  correct answer, valid in the answerSig cycle.
REQ-009 SHALL have port btnUp  in  1  debounced level input that increments the guess.
REQ-010 SHALL have port btnDown  in  1  debounced level input that decrements the guess.
REQ-011 SHALL have port btnSubmit  in  1  debounced level input that submits the guess.
REQ-012 SHALL have port scoreClr  in  1  pulse that clears score and roundsPlayed.
REQ-013 SHALL have port answering  out  1  high while in the ANSWER state.
REQ-014 SHALL have port guess  out  8  current player guess.
REQ-015 SHALL have port timeLeft  out  8  seconds remaining in the answer window.
REQ-016 SHALL have port resultValid  out  1  one-cycle pulse when a round is scored.
REQ-017 SHALL have port correct  out  1  last round answered correctly.
REQ-018 SHALL have port timedOut  out  1  last round ended by timeout.
REQ-019 SHALL have port score  out  8  count of correct rounds.
REQ-020 SHALL have port roundsPlayed  out  8  count of scored rounds.

Function
REQ-021 SHALL implement FSM states IDLE, ANSWER, CHECK and RESULT.
REQ-022 SHALL detect rising edges only on each button: edge = btn AND NOT registered previous value.
REQ-023 IDLE: on answerSig, SHALL latch numSpecial into target, set guess=0, timer=0, correct=0, timedOut=0, and enter ANSWER next cycle.
REQ-024 ANSWER: SHALL increment guess on a btnUp edge, saturating at MAX_GUESS.
REQ-025 ANSWER: SHALL decrement guess on a btnDown edge, saturating at 0.
REQ-026 ANSWER: SHALL leave guess unchanged when btnUp and btnDown edges occur in the same cycle.
REQ-027 ANSWER: SHALL increment timer on each secTick; timeLeft = TIMEOUT_S - timer, and 0 outside ANSWER.
REQ-028 ANSWER: a btnSubmit edge SHALL move to CHECK with timedOut=0.
REQ-029 ANSWER: when secTick would make timer reach TIMEOUT_S, SHALL move to CHECK with timedOut=1.
REQ-030 When submit and timeout occur in the same cycle, submit SHALL win (timedOut=0).
REQ-031 CHECK SHALL last exactly one cycle and set correct = (guess==target) AND NOT timedOut.
REQ-032 CHECK SHALL pulse resultValid for that one cycle and increment roundsPlayed.
REQ-033 CHECK SHALL increment score if the round is correct.
REQ-034 score and roundsPlayed SHALL both saturate at 255.
REQ-035 RESULT SHALL hold correct, timedOut and guess, count RESULT_S secTicks, then return to IDLE.
REQ-036 answerSig in ANSWER or RESULT SHALL abandon the current round without scoring and restart per REQ-023.
REQ-037 answerSig in CHECK SHALL be ignored; scoring completes first.
REQ-038 scoreClr SHALL zero score and roundsPlayed next cycle in any state.
REQ-039 scoreClr coincident with a CHECK increment: the clear SHALL win.
REQ-040 Button activity outside ANSWER SHALL be ignored.

Reset
REQ-041 Rst_n low SHALL immediately force IDLE and set all outputs and the target/timer registers to 0.
REQ-042 Rst_n low SHALL set the button previous-value registers to 1, so a button held through reset release produces no edge.
REQ-043 Reset asserted mid-round SHALL discard the round with no resultValid pulse.

Verification
REQ-044 SHALL cover: answerSig with numSpecial=5, 5 btnUp edges, then submit -> one resultValid pulse, correct=1, score=1, roundsPlayed=1.
REQ-045 SHALL cover: numSpecial=3, guess driven to 4, submit -> correct=0, score unchanged, roundsPlayed incremented.
REQ-046 SHALL cover: no submit, 10 secTicks (TIMEOUT_S=10) -> timedOut=1, correct=0 even when guess==target, timeLeft 10..0.
REQ-047 SHALL cover: btnDown at guess=0 -> guess stays 0; MAX_GUESS=7 with 9 btnUp edges -> guess=7; simultaneous up/down -> guess unchanged.
REQ-048 SHALL cover: submit edge in the same cycle as the 10th secTick -> timedOut=0; answerSig mid-ANSWER -> new target latched, guess=0, no resultValid.
REQ-049 SHALL cover: Rst_n pulsed low mid-ANSWER with btnUp held -> IDLE, all outputs 0, and no guess increment after release.

Source files
------------

// File: rtl/answer_check.sv
// answer_check: round controller for a guess-the-number game. Latches the
// answer, lets the player adjust and submit a guess within a timed window, then scores it.
module answer_check #(
   parameter int TIMEOUT_S = 10,
   parameter int RESULT_S  = 3,
   parameter int MAX_GUESS = 255
) (
   input  logic       Clk100M,
   input  logic       Rst_n,
   input  logic       secTick,
   input  logic       answerSig,
   input  logic [7:0] numSpecial,
   input  logic       btnUp,
   input  logic       btnDown,
   input  logic       btnSubmit,
   input  logic       scoreClr,
   output logic       answering,
   output logic [7:0] guess,
   output logic [7:0] timeLeft,
   output logic       resultValid,
   output logic       correct,
   output logic       timedOut,
   output logic [7:0] score,
   output logic [7:0] roundsPlayed
);

   typedef enum logic [1:0] {IDLE, ANSWER, CHECK, RESULT} state_t;

   localparam logic [7:0] timeoutLim = 8'(TIMEOUT_S);
   localparam logic [7:0] resultLim  = 8'(RESULT_S);
   localparam logic [7:0] guessMax   = 8'(MAX_GUESS);

   state_t     state;
   logic [7:0] target;
   logic [7:0] timer;
   logic [7:0] resCnt;
   logic       upPrev, downPrev, submitPrev;
   logic       upEdge, downEdge, submitEdge;
   logic       hit;

   assign upEdge     = btnUp & ~upPrev;
   assign downEdge   = btnDown & ~downPrev;
   assign submitEdge = btnSubmit & ~submitPrev;
   assign hit        = (guess == target);

   assign answering = (state == ANSWER);
   assign timeLeft  = answering ? (timeoutLim - timer) : 8'd0;

   function automatic logic [7:0] satInc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Scoring is committed on the same edge that enters CHECK, so while
   // resultValid is high correct/timedOut/score/roundsPlayed already hold the round's values.
   always_ff @(posedge Clk100M or negedge Rst_n) begin
      if (!Rst_n) begin
         state        <= IDLE;
         target       <= '0;
         timer        <= '0;
         resCnt       <= '0;
         guess        <= '0;
         correct      <= 1'b0;
         timedOut     <= 1'b0;
         resultValid  <= 1'b0;
         score        <= '0;
         roundsPlayed <= '0;
         // NOTE: previous-value registers reset high so a button held through reset release is not seen as a press.
         upPrev       <= 1'b1;
         downPrev     <= 1'b1;
         submitPrev   <= 1'b1;
      end else begin
         upPrev      <= btnUp;
         downPrev    <= btnDown;
         submitPrev  <= btnSubmit;
         // NOTE: default-low here, overridden below, keeps resultValid a single-cycle pulse.
         resultValid <= 1'b0;

         if (answerSig && state != CHECK) begin
            state    <= ANSWER;
            target   <= numSpecial;
            guess    <= '0;
            timer    <= '0;
            resCnt   <= '0;
            correct  <= 1'b0;
            timedOut <= 1'b0;
         end else begin
            case (state)
               ANSWER: begin
                  if (submitEdge) begin
                     state        <= CHECK;
                     timedOut     <= 1'b0;
                     correct      <= hit;
                     resultValid  <= 1'b1;
                     roundsPlayed <= satInc(roundsPlayed);
                     if (hit) score <= satInc(score);
                  end else if (secTick && (timer + 8'd1 == timeoutLim)) begin
                     state        <= CHECK;
                     timer        <= timer + 8'd1;
                     timedOut     <= 1'b1;
                     correct      <= 1'b0;
                     resultValid  <= 1'b1;
                     roundsPlayed <= satInc(roundsPlayed);
                  end else begin
                     if (secTick) timer <= timer + 8'd1;
                     if (upEdge && !downEdge && guess < guessMax)
                        guess <= guess + 8'd1;
                     else if (downEdge && !upEdge && guess != 8'd0)
                        guess <= guess - 8'd1;
                  end
               end
               CHECK: begin
                  state  <= RESULT;
                  resCnt <= '0;
               end
               RESULT: begin
                  if (secTick) begin
                     if (resCnt + 8'd1 == resultLim) state <= IDLE;
                     else resCnt <= resCnt + 8'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end

         if (scoreClr) begin
            score        <= '0;
            roundsPlayed <= '0;
         end
      end
   end

endmodule
